// File: rtl/key_pkg.sv
// Shared definitions for the push-button scanner and the logic that consumes
// its key events.
package key_pkg;

  // Widest key code needed for the largest supported channel count (32).
  localparam int MAX_CODE_W = 5;

  // Width of the key index: ceil(log2(n_keys)), but never less than one bit.
  function automatic int code_width(input int n_keys);
    return (n_keys > 1) ? $clog2(n_keys) : 1;
  endfunction

  // One key event as seen by a consumer such as the mode-selection FSM.
  typedef struct packed {
    logic [MAX_CODE_W-1:0] code;
    logic                  valid;
    logic                  is_repeat;
    logic                  multi;
  } key_event_t;

endpackage

// File: rtl/key_debounce.sv
// One button channel: a multi-flop synchroniser followed by a counter-based
// debouncer. The debounced level changes only after the synchronised input
// has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic key_in,
  output logic db
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Shift the raw asynchronous level through the synchroniser chain.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour; blocking ones would collapse the chain.
      sync <= {sync[SYNC_STAGES-2:0], key_in};
    end
  end

  // Accept a new level only after it has persisted for the full window;
  // any return to the current level restarts the count, so it never wraps.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (s == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_scanner.sv
// Multi-channel push-button front end: per-channel sync and debounce,
// press-edge detection, lowest-index priority encoding into a one-cycle key
// strobe, and optional auto-repeat of the most recently reported key.
module key_scanner
  import key_pkg::*;
#(
  parameter  int N_KEYS          = 3,
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 4,
  parameter  int REPEAT_CYCLES   = 0,
  localparam int CODE_W          = code_width(N_KEYS)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [N_KEYS-1:0] keys_in,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_repeat,
  output logic              multi_press,
  output logic [N_KEYS-1:0] keys_held
);

  localparam int               RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = (REPEAT_CYCLES > 0) ? RPT_W'(REPEAT_CYCLES - 1) : '0;
  localparam bit               RPT_EN   = (REPEAT_CYCLES > 0);

  // Whether a reported key is currently being followed for auto-repeat.
  typedef enum logic {TRK_IDLE, TRK_HELD} trk_state_t;

  trk_state_t        trk_state, nxt_state;
  logic [CODE_W-1:0] tracked, nxt_tracked;
  logic [RPT_W-1:0]  rpt_cnt, nxt_rcnt;
  logic [CODE_W-1:0] nxt_code;
  logic              nxt_valid, nxt_repeat, nxt_multi;

  logic [N_KEYS-1:0] db, held_q, press;
  logic [CODE_W-1:0] first_idx;
  logic              multi, trk_level;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .nrst   (nrst),
      .key_in (keys_in[i]),
      .db     (db[i])
    );
  end

  // Rising edges of the registered debounced levels; releases are ignored.
  assign press = keys_held & ~held_q;

  // Priority-encode the press edges and look up the tracked key's level.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path can leave it unassigned and infer a latch.
    first_idx = '0;
    trk_level = 1'b0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (press[i]) first_idx = CODE_W'(i);
    end
    for (int i = 0; i < N_KEYS; i++) begin
      if (tracked == CODE_W'(i)) trk_level = keys_held[i];
    end
    multi = |(press & (press - N_KEYS'(1)));
  end

  // Next event and tracking state: a fresh press always wins over a repeat.
  always_comb begin
    nxt_state   = trk_state;
    nxt_tracked = tracked;
    nxt_rcnt    = rpt_cnt;
    nxt_code    = key_code;
    nxt_valid   = 1'b0;
    nxt_repeat  = 1'b0;
    nxt_multi   = 1'b0;
    if (|press) begin
      nxt_state   = TRK_HELD;
      nxt_tracked = first_idx;
      nxt_rcnt    = '0;
      nxt_code    = first_idx;
      nxt_valid   = 1'b1;
      nxt_multi   = multi;
    end else if (trk_state == TRK_HELD) begin
      if (!trk_level) begin
        nxt_state = TRK_IDLE;
        nxt_rcnt  = '0;
      end else if (RPT_EN) begin
        if (rpt_cnt == RPT_LAST) begin
          nxt_rcnt   = '0;
          nxt_code   = tracked;
          nxt_valid  = 1'b1;
          nxt_repeat = 1'b1;
        end else begin
          nxt_rcnt = rpt_cnt + RPT_W'(1);
        end
      end
    end
  end

  // Register all outputs and tracking state; nothing leaves combinationally.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      keys_held   <= '0;
      held_q      <= '0;
      trk_state   <= TRK_IDLE;
      tracked     <= '0;
      rpt_cnt     <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_repeat  <= 1'b0;
      multi_press <= 1'b0;
    end else begin
      keys_held   <= db;
      held_q      <= keys_held;
      trk_state   <= nxt_state;
      tracked     <= nxt_tracked;
      rpt_cnt     <= nxt_rcnt;
      key_code    <= nxt_code;
      key_valid   <= nxt_valid;
      key_repeat  <= nxt_repeat;
      multi_press <= nxt_multi;
    end
  end

endmodule

// File: tb/tb_key_scanner.sv
// Directed bench for key_scanner: one instance with repeat disabled and one
// with REPEAT_CYCLES=5, both driven from the same button lines.
module tb_key_scanner;

  typedef struct {
    int at;
    int code;
    int rpt;
    int multi;
  } ev_t;

  logic       clk;
  logic       nrst;
  logic [2:0] keys_in;

  logic [1:0] a_code, b_code;
  logic       a_valid, b_valid, a_rep, b_rep, a_multi, b_multi;
  logic [2:0] a_held, b_held;

  int   checks;
  int   errors;
  int   cyc;
  ev_t  ev_a[$];
  ev_t  ev_b[$];
  ev_t  exp_q[$];
  logic [2:0] held_a[$];

  key_scanner #(.N_KEYS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)) dut (
    .clk(clk), .nrst(nrst), .keys_in(keys_in),
    .key_code(a_code), .key_valid(a_valid), .key_repeat(a_rep),
    .multi_press(a_multi), .keys_held(a_held)
  );

  key_scanner #(.N_KEYS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(5)) dut_rpt (
    .clk(clk), .nrst(nrst), .keys_in(keys_in),
    .key_code(b_code), .key_valid(b_valid), .key_repeat(b_rep),
    .multi_press(b_multi), .keys_held(b_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    ev_a.delete();
    ev_b.delete();
    held_a.delete();
    cyc = 0;
  endtask

  // Advance n cycles, logging strobes of both instances at each falling edge.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (a_valid) ev_a.push_back('{cyc, int'(a_code), int'(a_rep), int'(a_multi)});
      if (b_valid) ev_b.push_back('{cyc, int'(b_code), int'(b_rep), int'(b_multi)});
      held_a.push_back(a_held);
      cyc++;
    end
  endtask

  task automatic add_exp(input int at, input int code, input int rpt, input int multi);
    exp_q.push_back('{at, code, rpt, multi});
  endtask

  // Compare the logged strobes of one instance with the expected list.
  task automatic cmp_events(input string tag, input bit use_rpt);
    ev_t got[$];
    if (use_rpt) got = ev_b;
    else         got = ev_a;
    check({tag, ".count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s.ev%0d.at", tag, i),    got[i].at,    exp_q[i].at);
      check($sformatf("%s.ev%0d.code", tag, i),  got[i].code,  exp_q[i].code);
      check($sformatf("%s.ev%0d.rpt", tag, i),   got[i].rpt,   exp_q[i].rpt);
      check($sformatf("%s.ev%0d.multi", tag, i), got[i].multi, exp_q[i].multi);
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst    = 1'b0;
    keys_in = 3'b000;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    logic [2:0] held_or;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    nrst    = 1'b1;
    keys_in = 3'b000;

    // Asynchronous reset before any clock edge.
    #2 nrst = 1'b0;
    #1;
    check("rst.valid", a_valid, 0);
    check("rst.code", a_code, 0);
    check("rst.repeat", a_rep, 0);
    check("rst.multi", a_multi, 0);
    check("rst.held", a_held, 0);
    @(negedge clk);
    nrst = 1'b1;

    // Single press of key 1: one strobe seven edges after the first sample.
    do_reset();
    keys_in = 3'b010;
    clear_log();
    watch(14);
    add_exp(7, 1, 0, 0);
    cmp_events("press1", 1'b0);
    check("press1.held5", held_a[5], 3'b000);
    check("press1.held6", held_a[6], 3'b010);
    check("press1.held_end", a_held, 3'b010);
    check("press1.code_hold", a_code, 1);

    // Release produces no event; the code holds its last value.
    keys_in = 3'b000;
    clear_log();
    watch(14);
    cmp_events("release1", 1'b0);
    check("release1.held", a_held, 3'b000);
    check("release1.code_hold", a_code, 1);

    // Three-cycle glitch on key 0 is rejected.
    keys_in = 3'b001;
    clear_log();
    watch(3);
    keys_in = 3'b000;
    watch(12);
    cmp_events("glitch3", 1'b0);
    held_or = 3'b000;
    foreach (held_a[i]) held_or = held_or | held_a[i];
    check("glitch3.held0", held_or[0], 0);

    // Four-cycle pulse on key 0 is accepted exactly once.
    keys_in = 3'b001;
    clear_log();
    watch(4);
    keys_in = 3'b000;
    watch(16);
    add_exp(7, 0, 0, 0);
    cmp_events("pulse4", 1'b0);

    // Simultaneous press of keys 1 and 2.
    keys_in = 3'b110;
    clear_log();
    watch(14);
    add_exp(7, 1, 0, 1);
    cmp_events("multi", 1'b0);
    check("multi.held", a_held, 3'b110);
    keys_in = 3'b000;
    watch(14);

    // Auto-repeat of key 2, released so the debounced release lands
    // between the +20 strobe and the next expiry.
    do_reset();
    keys_in = 3'b100;
    clear_log();
    watch(22);
    keys_in = 3'b000;
    watch(28);
    add_exp(7, 2, 0, 0);
    add_exp(12, 2, 1, 0);
    add_exp(17, 2, 1, 0);
    add_exp(22, 2, 1, 0);
    add_exp(27, 2, 1, 0);
    cmp_events("repeat", 1'b1);
    check("repeat.held_end", b_held, 3'b000);

    // Key 2 pressed while key 0 repeats; its press coincides with a
    // repeat expiry of key 0 and takes over tracking.
    do_reset();
    keys_in = 3'b001;
    clear_log();
    watch(15);
    keys_in = 3'b101;
    watch(10);
    keys_in = 3'b100;
    watch(16);
    keys_in = 3'b000;
    watch(20);
    add_exp(7, 0, 0, 0);
    add_exp(12, 0, 1, 0);
    add_exp(17, 0, 1, 0);
    add_exp(22, 2, 0, 0);
    add_exp(27, 2, 1, 0);
    add_exp(32, 2, 1, 0);
    add_exp(37, 2, 1, 0);
    add_exp(42, 2, 1, 0);
    add_exp(47, 2, 1, 0);
    cmp_events("takeover", 1'b1);

    // Reset mid-debounce: full latency again afterwards.
    do_reset();
    keys_in = 3'b001;
    clear_log();
    watch(4);
    nrst = 1'b0;
    #1;
    check("rst_db.valid", a_valid, 0);
    check("rst_db.held", a_held, 3'b000);
    @(negedge clk);
    nrst = 1'b1;
    clear_log();
    watch(14);
    add_exp(7, 0, 0, 0);
    cmp_events("rst_db.after", 1'b0);

    // Reset mid-repeat, asserted while a repeat strobe is on the outputs.
    do_reset();
    keys_in = 3'b100;
    clear_log();
    watch(13);
    check("rst_rpt.pre_valid", b_valid, 1);
    nrst = 1'b0;
    #1;
    check("rst_rpt.valid", b_valid, 0);
    check("rst_rpt.repeat", b_rep, 0);
    check("rst_rpt.code", b_code, 0);
    check("rst_rpt.multi", b_multi, 0);
    check("rst_rpt.held", b_held, 3'b000);
    @(negedge clk);
    nrst = 1'b1;
    clear_log();
    watch(14);
    add_exp(7, 2, 0, 0);
    add_exp(12, 2, 1, 0);
    cmp_events("rst_rpt.after", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
